// File: rtl/f1_pkg.sv
// Shared types and constants for the random-delay block: state encoding,
// LFSR seed/taps and default widths.
package f1_pkg;

    localparam int LFSR_W_DEF = 7;
    localparam int PRE_W_DEF  = 16;

    // x^7 + x^3 + 1 Fibonacci form: feedback = s[6] ^ s[2]
    localparam logic [6:0] LFSR_SEED  = 7'h01;
    localparam int         LFSR_TAP_A = 6;
    localparam int         LFSR_TAP_B = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } delay_state_t;

endpackage

// File: rtl/lfsr7.sv
// Free-running Fibonacci LFSR, shifting left with feedback into bit 0.
// It is seeded to a non-zero value, so it never locks up at zero.
module lfsr7
    import f1_pkg::*;
#(
    parameter int W = LFSR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= W'(LFSR_SEED);
        end else begin
            q <= {q[W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
        end
    end

endmodule

// File: rtl/f1_random_delay.sv
// Random reaction-delay generator. A rising edge on start loads the current
// LFSR value as a tick count, and time_out pulses once when that count expires.
module f1_random_delay
    import f1_pkg::*;
#(
    parameter int LFSR_W = LFSR_W_DEF,
    parameter int PRE_W  = PRE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PRE_W-1:0]  tick_period,
    output logic              time_out,
    output logic              busy,
    output logic [LFSR_W-1:0] delay_val,
    output logic [LFSR_W-1:0] lfsr_out
);

    delay_state_t      state, state_next;
    logic [PRE_W-1:0]  prescaler;
    logic [LFSR_W-1:0] remaining;
    logic              start_q;
    logic              armed;
    logic              start_rise;
    logic              tick_hit;
    logic              expire;

    lfsr7 #(.W(LFSR_W)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_out)
    );

    // armed blocks a start that was already high through reset from
    // being seen as a fresh edge.
    assign start_rise = start && !start_q && armed;
    assign tick_hit   = (prescaler == tick_period);
    assign busy       = (state == ST_COUNT);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        expire     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_rise) state_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (!start) begin
                    state_next = ST_IDLE;
                end else if (tick_hit && remaining == LFSR_W'(1)) begin
                    state_next = ST_DONE;
                    expire     = 1'b1;
                end
            end
            ST_DONE: begin
                if (!start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            prescaler <= '0;
            remaining <= '0;
            delay_val <= '0;
            start_q   <= 1'b0;
            armed     <= 1'b0;
            time_out  <= 1'b0;
        end else begin
            state    <= state_next;
            start_q  <= start;
            time_out <= expire;
            if (!start) armed <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        delay_val <= lfsr_out;
                        remaining <= lfsr_out;
                        prescaler <= '0;
                    end
                end
                ST_COUNT: begin
                    // tick_period is compared live, so a change applies on the next compare
                    if (start) begin
                        if (tick_hit) begin
                            prescaler <= '0;
                            remaining <= remaining - LFSR_W'(1);
                        end else begin
                            prescaler <= prescaler + PRE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/f1_random_delay.md
F1_RANDOM_DELAY -- requirements
Module: f1_random_delay

Interface
REQ-001 SHALL have parameter LFSR_W, default 7, meaning width of the pseudo-random generator and of the delay value.
REQ-002 SHALL have parameter PRE_W, default 16, meaning width of the tick prescaler and of tick_period.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: delay request level, driven by the light sequencer's cmd_delay.
REQ-006 SHALL have port tick_period, input, PRE_W bits: clk cycles per delay tick, minus 1.
REQ-007 SHALL have port time_out, output, 1 bit: one-cycle pulse when the random delay expires; fed back to the sequencer as trigger.
REQ-008 SHALL have port busy, output, 1 bit: high while the delay is counting.
REQ-009 SHALL have port delay_val, output, LFSR_W bits: delay in ticks captured for the current or last run.
REQ-010 SHALL have port lfsr_out, output, LFSR_W bits: current LFSR state, for debug.

Function
REQ-011 SHALL run the LFSR freely every cycle as Fibonacci x^7+x^3+1: next = {s[5:0], s[6]^s[2]}; seed 7'h01; never reaches zero; period 127.
REQ-012 SHALL implement states IDLE, COUNT, DONE.
REQ-013 IDLE: SHALL detect a start rising edge (start=1, registered previous start=0); on that edge capture delay_val<=lfsr_out, set remaining<=lfsr_out, set prescaler<=0, and go to COUNT.
REQ-014 COUNT: each cycle, SHALL set prescaler<=prescaler+1, or, if prescaler==tick_period, set prescaler<=0 and remaining<=remaining-1.
REQ-015 COUNT: when prescaler==tick_period and remaining==1, SHALL assert time_out (registered, 1 cycle) and go to DONE.
REQ-016 Latency: when the rising edge is sampled at edge E0, time_out SHALL be high for exactly the cycle following edge E0+delay_val*(tick_period+1).
REQ-017 COUNT: if start is sampled low, SHALL abort to IDLE with no time_out pulse; delay_val keeps its value.
REQ-018 DONE: SHALL wait until start is sampled low, then go to IDLE; a start held high SHALL NOT re-trigger.
REQ-019 busy SHALL be 1 exactly when the state is COUNT.
REQ-020 tick_period SHALL be sampled live each cycle; changing it mid-COUNT is legal and takes effect on the next compare.
REQ-021 tick_period=0 SHALL give one tick per cycle, so the delay equals delay_val cycles.
REQ-022 Simultaneous rst and start: rst SHALL win.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL set: state IDLE; lfsr 7'h01; prescaler 0; remaining 0; delay_val 0; previous start 0; time_out 0; busy 0.
REQ-024 Reset mid-COUNT SHALL abort with no time_out; the first start rising edge after reset SHALL be detected only if start was sampled low after reset release.

Structure
REQ-025 Shared package f1_pkg SHALL hold the delay state enum, LFSR seed and tap constants, and LFSR_W/PRE_W defaults.
REQ-026 The LFSR SHALL be a separate sub-module lfsr7 (ports clk, rst, q); the FSM, prescaler and edge detect SHALL stay in f1_random_delay.

Verification
REQ-027 Reset release, start=0: lfsr_out SHALL read 01, 02, 04, 09, 12 (hex) on successive cycles, and SHALL repeat after 127 cycles.
REQ-028 tick_period=0; start rising edge sampled when lfsr_out=04 -> delay_val=04, busy for 4 cycles, time_out single pulse 4 cycles after E0.
REQ-029 tick_period=2; rising edge sampled when lfsr_out=09 -> time_out pulse 27 cycles after E0; start held high afterwards -> no second pulse until start goes low, then high again.
REQ-030 Abort: start drops 5 cycles into a 27-cycle COUNT -> IDLE next cycle, busy=0, no time_out ever.
REQ-031 rst asserted mid-COUNT with start held high -> all outputs 0, lfsr_out=01; no time_out until start goes low, then high again.
REQ-032 Back-to-back: start pulses low/high right after time_out -> new run captures the current lfsr_out and runs with the correct latency.
